shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter: WIDTH, default 16, word width in bits (>= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle pulse; begins a new frame.
REQ-005 Port: sin  input  1  serial data bit.
REQ-006 Port: sin_valid  input  1  qualifies sin; one bit accepted per cycle when high in SHIFT.
REQ-007 Port: word  output  WIDTH  assembled parallel word.
REQ-008 Port: word_valid  output  1  word holds a complete, unconsumed frame.
REQ-009 Port: word_ready  input  1  consumer accepts word when high with word_valid.
REQ-010 Port: busy  output  1  high while in SHIFT.
REQ-011 Port: overrun  output  1  sticky error flag.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and HOLD.
REQ-013 IDLE: start=1 -> SHIFT, bit counter cleared to 0, internal shift register cleared to 0; sin_valid ignored.
REQ-014 SHIFT: each cycle with sin_valid=1, the block SHALL shift sin into the internal register and increment the counter; sin_valid=0 holds register and counter.
REQ-015 Default bit order SHALL be LSB-first: register <= {sin, register[WIDTH-1:1]}, so the first bit received lands in word[0].
REQ-016 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL count 0..WIDTH-1 with no wrap inside a frame.
REQ-017 On the accepted bit with counter = WIDTH-1: word <= final shifted value, word_valid <= 1, state -> HOLD; word_valid SHALL rise on the clock edge that samples the last bit (no extra latency).
REQ-018 HOLD: word and word_valid SHALL remain stable until word_valid && word_ready, then word_valid <= 0 and state -> IDLE.
REQ-019 start in SHIFT SHALL abort the partial frame: counter and register cleared, state remains SHIFT; word and word_valid unaffected.
REQ-020 start and the final sin_valid in the same SHIFT cycle: start SHALL win; no word is produced.
REQ-021 start in HOLD SHALL be ignored for framing and SHALL set overrun to 1.
REQ-022 overrun SHALL remain 1 until reset.
REQ-023 sin_valid in HOLD or IDLE SHALL be discarded without side effects.
REQ-024 word SHALL keep its last value after the handshake until the next frame completes.
REQ-025 busy SHALL equal (state == SHIFT), registered, no combinational path from inputs.
REQ-026 word_ready in IDLE or SHIFT SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force state IDLE, counter 0, internal register 0, word 0, word_valid 0, busy 0, overrun 0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard all frame data; the first valid frame after release SHALL require a new start.
REQ-029 Deassertion of rst_n is synchronized externally; the block SHALL not sample inputs in the cycle rst_n is low.

Configuration
REQ-030 Macro SHIFT_DESERIALIZER_MSB_FIRST_EN SHALL select bit order at compile time.
REQ-031 Defined: register <= {register[WIDTH-2:0], sin}; first bit received lands in word[WIDTH-1] (pairs with a left-shifting transmitter).
REQ-032 Undefined: LSB-first per REQ-015 (pairs with a right-shifting transmitter emitting bit 0 each cycle); all other behaviour identical.

Verification (WIDTH=16)
REQ-033 Reset, start, 16 contiguous LSB-first bits of 16'hA5C3, word_ready=1 -> word=16'hA5C3, word_valid high exactly 1 cycle, busy high 16 cycles.
REQ-034 Same frame with sin_valid low on alternate cycles -> word=16'hA5C3 after 32 cycles; no corruption from stalled cycles.
REQ-035 Frame 16'h8001, word_ready=0 for 5 cycles, then 1 -> word_valid held 6 cycles, word stable at 16'h8001, then IDLE.
REQ-036 start after 7 bits, then 16 bits of 16'h1234 -> word=16'h1234 only; start during HOLD -> overrun=1, word unchanged, overrun stays 1 after a further frame.
REQ-037 rst_n pulsed low after 10 bits -> all outputs 0 asynchronously; 6 further sin_valid bits without start -> word_valid stays 0.
REQ-038 With SHIFT_DESERIALIZER_MSB_FIRST_EN defined, MSB-first bits of 16'hA5C3 -> word=16'hA5C3; same bits LSB-first -> word=16'hC3A5.

Source files
------------

// File: rtl/shift_deserializer.sv
// shift_deserializer: assembles WIDTH serial bits into a word with start/abort framing and a valid/ready output.
// Define SHIFT_DESERIALIZER_MSB_FIRST_EN for MSB-first bit order; LSB-first otherwise.
module shift_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, shifted, word_nxt;
    logic             word_valid_nxt, overrun_nxt;

`ifdef SHIFT_DESERIALIZER_MSB_FIRST_EN
    assign shifted = {sreg[WIDTH-2:0], sin};
`else
    assign shifted = {sin, sreg[WIDTH-1:1]};
`endif

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sreg_nxt       = sreg;
        word_nxt       = word;
        word_valid_nxt = word_valid;
        overrun_nxt    = overrun;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sreg_nxt  = '0;
                end
            end
            SHIFT: begin
                // start outranks a coinciding final bit: the frame restarts instead of completing
                if (start) begin
                    cnt_nxt  = '0;
                    sreg_nxt = '0;
                end else if (sin_valid) begin
                    sreg_nxt = shifted;
                    if (cnt == CW'(WIDTH - 1)) begin
                        word_nxt       = shifted;
                        word_valid_nxt = 1'b1;
                        state_nxt      = HOLD;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (start) overrun_nxt = 1'b1;
                if (word_ready) begin
                    word_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sreg       <= sreg_nxt;
            word       <= word_nxt;
            word_valid <= word_valid_nxt;
            overrun    <= overrun_nxt;
        end
    end

    assign busy = (state == SHIFT);
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: table-driven frames plus hand-written corner sequences, scoreboard-checked at the output handshake.
module tb_shift_deserializer;
    localparam int W = 16;
`ifdef SHIFT_DESERIALIZER_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         word_ready = 1'b0;
    logic [W-1:0] word;
    logic         word_valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int wv_cnt = 0;
    logic [W-1:0] sbq[$];

    typedef struct {
        logic [W-1:0] data;
        bit           stall;
        int           hold;
        int           exp_busy;
    } vec_t;
    vec_t vecs[5];

    shift_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_valid(sin_valid),
        .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: each handshake seen here pops the oldest expected word.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (word_valid) wv_cnt++;
        if (rst_n && word_valid && word_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected no word", word);
            end else begin
                chk("sb_word", word, sbq.pop_front());
            end
        end
    end

    task automatic drive(input logic st, input logic sv, input logic b);
        start = st;
        sin_valid = sv;
        sin = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        sin_valid = 1'b0;
        sin = 1'b0;
    endtask

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // swap=1 sends the bits in the order opposite to the configured one
    task automatic run_frame(input logic [W-1:0] d, input bit stall, input bit swap);
        logic [W-1:0] exp;
        bit rev;
        rev = MSB ^ swap;
        exp = swap ? bitrev(d) : d;
        sbq.push_back(exp);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (stall) drive(1'b0, 1'b0, 1'b0);
            chk("wv_before_last", word_valid, 1'b0);
            drive(1'b0, 1'b1, rev ? d[W-1-i] : d[i]);
        end
        chk("wv_at_last", word_valid, 1'b1);
        chk("word_at_last", word, exp);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, 0, 16};
        vecs[1] = '{16'hA5C3, 1'b1, 0, 32};
        vecs[2] = '{16'h8001, 1'b0, 5, 16};
        vecs[3] = '{16'hFFFF, 1'b0, 2, 16};
        vecs[4] = '{16'h0000, 1'b1, 1, 32};

        #12;
        chk("rst_word", word, 0);
        chk("rst_wv", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            busy_cnt = 0;
            wv_cnt = 0;
            word_ready = (vecs[k].hold == 0);
            run_frame(vecs[k].data, vecs[k].stall, 1'b0);
            for (int j = 0; j < vecs[k].hold; j++) begin
                drive(1'b1 & 1'b0, 1'b1, 1'b1);
                chk("hold_word", word, vecs[k].data);
            end
            word_ready = 1'b1;
            drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b0);
            chk("vec_wv_cnt", wv_cnt, vecs[k].hold + 1);
            chk("vec_busy_cnt", busy_cnt, vecs[k].exp_busy);
            chk("vec_idle_wv", word_valid, 0);
            chk("vec_idle_busy", busy, 0);
            chk("vec_word_kept", word, vecs[k].data);
        end

        word_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1);
        run_frame(16'h1234, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_word", word, 16'h1234);
        chk("abort_wv", word_valid, 0);

        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("race_wv", word_valid, 0);
        chk("race_busy", busy, 1);
        chk("race_word", word, 16'h1234);

        word_ready = 1'b0;
        run_frame(16'h5A5A, 1'b0, 1'b0);
        chk("pre_ovr", overrun, 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("ovr_set", overrun, 1);
        chk("ovr_word", word, 16'h5A5A);
        chk("ovr_wv", word_valid, 1);
        chk("ovr_busy", busy, 0);
        word_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        run_frame(16'h0F0F, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", overrun, 1);

        run_frame(16'hA5C3, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("swap_word", word, 16'hC3A5);

        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word", word, 0);
        chk("arst_wv", word_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1);
        chk("post_rst_wv", word_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_word", word, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
